st_encoder_buffer: RTL and testbench

//  Store-side counterpart of the load decoder. Encodes sb/sh/sw store data into the data-memory lane format.

---
 rtl/st_encoder_buffer_pkg.sv | 22 ++
 rtl/st_encoder_buffer_if.sv | 27 ++
 rtl/st_encoder_buffer_enc.sv | 35 +++
 rtl/st_encoder_buffer.sv | 92 +++++++++
 tb/tb_st_encoder_buffer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/st_encoder_buffer_pkg.sv
// Shared store-path definitions: funct3 store encodings, byte-enable patterns
// and the FIFO entry layout used by the store encoder buffer.
package st_encoder_buffer_pkg;

  localparam int ST_DATA_W = 32;
  localparam int ST_ADDR_W = 32;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic [ST_ADDR_W-1:0] addr;
    logic [ST_DATA_W-1:0] wd;
    logic [3:0]           be;
  } st_entry_t;

endpackage

// File: rtl/st_encoder_buffer_if.sv
// Store request and data-memory write port bundled together; the buffer
// takes the slave view, the MEM stage / memory model drives the master view.
interface st_encoder_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  st_valid;
  logic                  st_ready;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [DATA_WIDTH-1:0] WD;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [3:0]            mem_be;

  modport master (
    output st_valid, funct3, st_addr, WD, mem_ready,
    input  st_ready, mem_valid, mem_addr, mem_wd, mem_be
  );

  modport slave (
    input  st_valid, funct3, st_addr, WD, mem_ready,
    output st_ready, mem_valid, mem_addr, mem_wd, mem_be
  );
endinterface

// File: rtl/st_encoder_buffer_enc.sv
// Combinational store encoder: places rs2 bytes into the memory lane order
// that the load decoder undoes, and produces the matching byte enables.
module st_encoder
  import st_encoder_buffer_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [ST_DATA_W-1:0] wd_in,
  output logic [ST_DATA_W-1:0] wd,
  output logic [3:0]           be,
  output logic                 legal
);

  // Lanes are byte-reversed relative to rs2 so a load of the same width round-trips.
  always_comb begin
    wd    = '0;
    be    = '0;
    legal = 1'b1;
    case (funct3)
      F3_SB: begin
        wd = {24'b0, wd_in[7:0]};
        be = BE_BYTE;
      end
      F3_SH: begin
        wd = {16'b0, wd_in[7:0], wd_in[15:8]};
        be = BE_HALF;
      end
      F3_SW: begin
        wd = {wd_in[7:0], wd_in[15:8], wd_in[23:16], wd_in[31:24]};
        be = BE_WORD;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/st_encoder_buffer.sv
// Store encoder buffer: encodes sb/sh/sw requests and queues them in a small
// FIFO that drains to data memory, decoupling the pipeline from memory stalls.
module st_encoder_buffer
  import st_encoder_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  st_encoder_buffer_if.slave    bus,
  output logic                  empty,
  output logic                  err
);

  localparam int PW = $clog2(DEPTH);

  st_entry_t             entries [DEPTH];
  st_entry_t             new_entry;
  st_entry_t             head;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic [DATA_WIDTH-1:0] enc_wd;
  logic [3:0]            enc_be;
  logic                  enc_legal;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic                  push;
  logic                  pop;

  st_encoder u_enc (
    .funct3 (bus.funct3),
    .wd_in  (bus.WD),
    .wd     (enc_wd),
    .be     (enc_be),
    .legal  (enc_legal)
  );

  // Ready and valid come only from the registered count, so neither side sees the other combinationally.
  assign bus.st_ready  = (count != (PW+1)'(DEPTH));
  assign empty         = (count == '0);
  assign bus.mem_valid = !empty;

  assign push = bus.st_valid && bus.st_ready && enc_legal;
  assign pop  = bus.mem_valid && bus.mem_ready;

  assign new_entry = '{addr: bus.st_addr, wd: enc_wd, be: enc_be};

  assign head          = entries[rd_ptr];
  assign head_addr     = head.addr;
  assign bus.mem_addr  = head_addr;
  assign bus.mem_wd    = head.wd;
  assign bus.mem_be    = head.be;

  // Storage is deliberately left out of reset; its contents are ignored while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for any illegal store width offered, whether or not it could have been accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (bus.st_valid && !enc_legal) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_st_encoder_buffer.sv
// Directed testbench for st_encoder_buffer: encoding, ordering, stalls,
// illegal funct3 handling and asynchronous reset.
module tb_st_encoder_buffer;

  logic clk;
  logic rst_n;
  logic empty;
  logic err;
  int   pass_cnt;
  int   total_cnt;

  st_encoder_buffer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  st_encoder_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .empty (empty),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] load_word(input logic [31:0] lanes);
    return {lanes[7:0], lanes[15:8], lanes[23:16], lanes[31:24]};
  endfunction

  task automatic set_store(input logic v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = v;
    bus.funct3   = f3;
    bus.st_addr  = a;
    bus.WD       = d;
  endtask

  task automatic test_reset();
    set_store(1'b0, 3'b000, 32'h0, 32'h0);
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    total_cnt++; if (bus.st_ready !== 1'b1) $display("[TB] FAIL reset_st_ready got %b expected 1", bus.st_ready); else pass_cnt++;
    total_cnt++; if (bus.mem_valid !== 1'b0) $display("[TB] FAIL reset_mem_valid got %b expected 0", bus.mem_valid); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty got %b expected 1", empty); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("[TB] FAIL reset_err got %b expected 0", err); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sw();
    bus.mem_ready = 1'b0;
    set_store(1'b1, 3'b010, 32'h0000_0100, 32'h1122_3344);
    #1;
    total_cnt++; if (bus.mem_valid !== 1'b0) $display("[TB] FAIL sw_no_comb_path got %b expected 0", bus.mem_valid); else pass_cnt++;
    tick();
    set_store(1'b0, 3'b000, 32'h0, 32'h0);
    total_cnt++; if (bus.mem_valid !== 1'b1) $display("[TB] FAIL sw_mem_valid got %b expected 1", bus.mem_valid); else pass_cnt++;
    total_cnt++; if (bus.mem_wd !== 32'h4433_2211) $display("[TB] FAIL sw_wd got %h expected 44332211", bus.mem_wd); else pass_cnt++;
    total_cnt++; if (bus.mem_be !== 4'b1111) $display("[TB] FAIL sw_be got %b expected 1111", bus.mem_be); else pass_cnt++;
    total_cnt++; if (bus.mem_addr !== 32'h0000_0100) $display("[TB] FAIL sw_addr got %h expected 00000100", bus.mem_addr); else pass_cnt++;
    total_cnt++; if (load_word(bus.mem_wd) !== 32'h1122_3344) $display("[TB] FAIL sw_roundtrip got %h expected 11223344", load_word(bus.mem_wd)); else pass_cnt++;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    total_cnt++; if (empty !== 1'b1) $display("[TB] FAIL sw_drained got %b expected 1", empty); else pass_cnt++;
  endtask

  task automatic test_sh_sb();
    bus.mem_ready = 1'b1;
    set_store(1'b1, 3'b001, 32'h0000_0104, 32'hABCD_8001);
    tick();
    set_store(1'b1, 3'b000, 32'h0000_0106, 32'hFFFF_FF85);
    total_cnt++; if (bus.mem_wd !== 32'h0000_0180) $display("[TB] FAIL sh_wd got %h expected 00000180", bus.mem_wd); else pass_cnt++;
    total_cnt++; if (bus.mem_be !== 4'b0011) $display("[TB] FAIL sh_be got %b expected 0011", bus.mem_be); else pass_cnt++;
    tick();
    set_store(1'b0, 3'b000, 32'h0, 32'h0);
    total_cnt++; if (bus.mem_wd !== 32'h0000_0085) $display("[TB] FAIL sb_wd got %h expected 00000085", bus.mem_wd); else pass_cnt++;
    total_cnt++; if (bus.mem_be !== 4'b0001) $display("[TB] FAIL sb_be got %b expected 0001", bus.mem_be); else pass_cnt++;
    total_cnt++; if (bus.mem_addr !== 32'h0000_0106) $display("[TB] FAIL sb_addr got %h expected 00000106", bus.mem_addr); else pass_cnt++;
    tick();
    bus.mem_ready = 1'b0;
    total_cnt++; if (empty !== 1'b1) $display("[TB] FAIL shsb_drained got %b expected 1", empty); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bus.mem_ready = 1'b0;
    set_store(1'b1, 3'b010, 32'h0000_0200, 32'hA0A0_A0A1);
    tick();
    set_store(1'b1, 3'b000, 32'h0000_0204, 32'h0000_00B2);
    tick();
    set_store(1'b1, 3'b001, 32'h0000_0208, 32'h0000_C3C4);
    total_cnt++; if (bus.st_ready !== 1'b0) $display("[TB] FAIL full_st_ready got %b expected 0", bus.st_ready); else pass_cnt++;
    total_cnt++; if (bus.mem_wd !== 32'hA1A0_A0A0) $display("[TB] FAIL full_head_wd got %h expected a1a0a0a0", bus.mem_wd); else pass_cnt++;
    tick();
    total_cnt++; if (bus.mem_addr !== 32'h0000_0200) $display("[TB] FAIL stall_addr got %h expected 00000200", bus.mem_addr); else pass_cnt++;
    total_cnt++; if (bus.mem_wd !== 32'hA1A0_A0A0) $display("[TB] FAIL stall_wd got %h expected a1a0a0a0", bus.mem_wd); else pass_cnt++;
    total_cnt++; if (bus.mem_be !== 4'b1111) $display("[TB] FAIL stall_be got %b expected 1111", bus.mem_be); else pass_cnt++;
    bus.mem_ready = 1'b1;
    tick();
    total_cnt++; if (bus.mem_addr !== 32'h0000_0204) $display("[TB] FAIL order_b_addr got %h expected 00000204", bus.mem_addr); else pass_cnt++;
    total_cnt++; if (bus.mem_wd !== 32'h0000_00B2) $display("[TB] FAIL order_b_wd got %h expected 000000b2", bus.mem_wd); else pass_cnt++;
    total_cnt++; if (bus.st_ready !== 1'b1) $display("[TB] FAIL after_pop_st_ready got %b expected 1", bus.st_ready); else pass_cnt++;
    tick();
    set_store(1'b0, 3'b000, 32'h0, 32'h0);
    total_cnt++; if (bus.mem_addr !== 32'h0000_0208) $display("[TB] FAIL pushpop_addr got %h expected 00000208", bus.mem_addr); else pass_cnt++;
    total_cnt++; if (bus.mem_wd !== 32'h0000_C4C3) $display("[TB] FAIL pushpop_wd got %h expected 0000c4c3", bus.mem_wd); else pass_cnt++;
    total_cnt++; if (bus.mem_be !== 4'b0011) $display("[TB] FAIL pushpop_be got %b expected 0011", bus.mem_be); else pass_cnt++;
    total_cnt++; if (bus.st_ready !== 1'b1) $display("[TB] FAIL pushpop_count got st_ready %b expected 1", bus.st_ready); else pass_cnt++;
    total_cnt++; if (empty !== 1'b0) $display("[TB] FAIL pushpop_not_empty got %b expected 0", empty); else pass_cnt++;
    tick();
    bus.mem_ready = 1'b0;
    total_cnt++; if (empty !== 1'b1) $display("[TB] FAIL b2b_drained got %b expected 1", empty); else pass_cnt++;
  endtask

  task automatic test_illegal();
    bus.mem_ready = 1'b0;
    set_store(1'b1, 3'b011, 32'h0000_0300, 32'hDEAD_BEEF);
    tick();
    set_store(1'b0, 3'b000, 32'h0, 32'h0);
    total_cnt++; if (empty !== 1'b1) $display("[TB] FAIL illegal_empty got %b expected 1", empty); else pass_cnt++;
    total_cnt++; if (bus.mem_valid !== 1'b0) $display("[TB] FAIL illegal_mem_valid got %b expected 0", bus.mem_valid); else pass_cnt++;
    total_cnt++; if (bus.st_ready !== 1'b1) $display("[TB] FAIL illegal_st_ready got %b expected 1", bus.st_ready); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (err !== 1'b1) $display("[TB] FAIL illegal_err_sticky got %b expected 1", err); else pass_cnt++;
  endtask

  task automatic test_reset_mid_drain();
    bus.mem_ready = 1'b0;
    set_store(1'b1, 3'b010, 32'h0000_0400, 32'h0102_0304);
    tick();
    set_store(1'b1, 3'b010, 32'h0000_0404, 32'h0506_0708);
    tick();
    set_store(1'b0, 3'b000, 32'h0, 32'h0);
    total_cnt++; if (bus.mem_valid !== 1'b1) $display("[TB] FAIL pending_mem_valid got %b expected 1", bus.mem_valid); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.mem_valid !== 1'b0) $display("[TB] FAIL async_mem_valid got %b expected 0", bus.mem_valid); else pass_cnt++;
    total_cnt++; if (bus.st_ready !== 1'b1) $display("[TB] FAIL async_st_ready got %b expected 1", bus.st_ready); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("[TB] FAIL async_err_clear got %b expected 0", err); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    total_cnt++; if (empty !== 1'b1) $display("[TB] FAIL post_reset_empty got %b expected 1", empty); else pass_cnt++;
    total_cnt++; if (bus.mem_valid !== 1'b0) $display("[TB] FAIL post_reset_mem_valid got %b expected 0", bus.mem_valid); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    bus.mem_ready = 1'b0;
    set_store(1'b0, 3'b000, 32'h0, 32'h0);
    test_reset();
    test_sw();
    test_sh_sb();
    test_back_to_back();
    test_illegal();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
